uart_tx_flex: RTL and testbench
===============================

UART_TX_FLEX -- requirements
Module: uart_tx_flex

Interface
REQ-001 Parameter DATA_W_MAX, default 9: widest supported data field in bits; legal range 5..9.
REQ-002 Parameter BIT_LEN_W, default 32: width of the bit-period input.
REQ-003 Port i_clk, input, 1: the single clock; every flop is rising-edge.
REQ-004 Port i_nrst, input, 1: reset, synchronous and active-low.
REQ-005 Port i_valid, input, 1: frame request.
REQ-006 Port o_ready, output, 1: block can accept a frame this cycle.
REQ-007 Port i_data, input, DATA_W_MAX: payload; the low i_data_bits bits are used.
REQ-008 Port i_data_bits, input, 4: data-field length in bits.
REQ-009 Port i_bit_length, input, BIT_LEN_W: clocks per bit.
REQ-010 Port i_msb_first, input, 1: 1 = MSB first, 0 = LSB first.
REQ-011 Port i_parity_mode, input, 3: parity selection, of type uart_parity_t.
REQ-012 Port i_stop2, input, 1: 1 = two stop bits.
REQ-013 Port i_cts, input, 1: clear-to-send, active-high.
REQ-014 Port i_hw_flow_control_enable, input, 1: 1 = i_cts gates acceptance.
REQ-015 Port o_tx, output, 1: serial line; idle level is 1.
REQ-016 Port o_busy, output, 1: a frame is in progress.
REQ-017 Port o_done, output, 1: one-cycle pulse at frame completion.

Function
REQ-018 A frame SHALL be accepted only in a cycle where i_valid and o_ready are both 1.
REQ-019 o_ready SHALL equal (state==IDLE) AND (i_cts OR NOT i_hw_flow_control_enable).
REQ-020 On acceptance, i_data, i_data_bits, i_bit_length, i_msb_first, i_parity_mode and i_stop2 SHALL be captured; later input changes SHALL NOT affect the frame in progress.
REQ-021 State sequence SHALL be IDLE -> START -> DATA -> PARITY (only when the mode is not NONE) -> STOP -> STOP2 (only when i_stop2 was set) -> IDLE.
REQ-022 o_tx SHALL be registered; with acceptance in cycle N, o_tx SHALL be 0 from cycle N+1.
REQ-023 Each bit SHALL last max(i_bit_length,1) clocks.
REQ-024 DATA SHALL emit exactly i_data_bits bits; values below 5 SHALL be treated as 5, values above DATA_W_MAX as DATA_W_MAX.
REQ-025 Parity bit: EVEN = XOR of the sent data bits; ODD = its inverse; MARK = 1; SPACE = 0.
REQ-026 o_tx SHALL be 1 during STOP, STOP2 and IDLE.
REQ-027 o_busy SHALL be 1 from cycle N+1 until the last stop-bit clock, inclusive.
REQ-028 o_done SHALL pulse, and state SHALL be IDLE, in the cycle after the last stop-bit clock.
REQ-029 A new request accepted in the o_done cycle SHALL start its start bit on the next cycle, with no idle gap between frames.
REQ-030 i_cts deasserting mid-frame SHALL NOT abort or stretch the frame.
REQ-031 i_parity_mode values outside the enumeration SHALL be treated as NONE.

Reset
REQ-032 When i_nrst=0 at a clock edge, outputs SHALL become: state IDLE, o_tx=1, o_busy=0, o_done=0, counters 0.
REQ-033 A reset mid-frame SHALL abort the frame and return o_tx to 1 at that edge; no o_done SHALL be produced for the aborted frame.

Configuration
REQ-034 With macro UART_TX_PARITY_EN defined, REQ-021/025/031 parity behaviour SHALL be compiled in.
REQ-035 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, i_parity_mode SHALL be ignored, and every frame SHALL be sent without parity.

Structure
REQ-036 uart_pkg SHALL hold the uart_parity_t enum (NONE=0, EVEN=1, ODD=2, MARK=3, SPACE=4), the TX state enum, and the constants UART_DATA_W_MIN=5 and UART_DATA_W_MAX=9.
REQ-037 Bit timing SHALL live in a sub-module uart_baud_cnt; it takes a load and a period input and outputs a one-cycle bit_end pulse.

Verification
REQ-038 8N1, LSB-first, bit_length=4, data 0xA5 -> o_tx 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; o_done at clock 41 after acceptance.
REQ-039 7E2, MSB-first, bit_length=2, data 0x55 -> data 1010101, parity 0, two stop bits; o_busy high for 22 clocks.
REQ-040 Flow control on, i_cts=0 with i_valid=1 -> o_ready=0 and o_tx stays 1; raising i_cts -> accepted the same cycle; dropping i_cts mid-frame -> frame completes unchanged.
REQ-041 Two back-to-back 5O1 frames, bit_length=0 -> second start bit directly follows the first stop bit, with each bit lasting 1 clock.
REQ-042 Reset asserted during DATA of 9N1 -> o_tx=1 and o_ready=1 after reset releases, with no o_done pulse.
REQ-043 Build without UART_TX_PARITY_EN, parity_mode=ODD, 8 bits -> 10-bit frame with no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmitter types and data-width limits.
// UART_TX_PARITY_EN adds the PARITY state to the TX state enum.
package uart_pkg;

    localparam int UART_DATA_W_MIN = 5;
    localparam int UART_DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } uart_parity_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4,
        TX_STOP2  = 3'd5
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reloads on load or at terminal count, pulses bit_end
// on the last clock of each bit.
module uart_baud_cnt #(
    parameter int BIT_LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 load,
    input  logic                 en,
    input  logic [BIT_LEN_W-1:0] period,
    output logic                 bit_end
);

    logic [BIT_LEN_W-1:0] cnt;
    logic [BIT_LEN_W-1:0] reload;

    // A zero period behaves like a one-clock bit.
    assign reload  = (period == '0) ? '0 : period - BIT_LEN_W'(1);
    assign bit_end = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (en) begin
            cnt <= (cnt == '0) ? reload : cnt - BIT_LEN_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_flex.sv
// Configurable UART transmitter with per-frame width, bit order, parity and stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------
// TX_IDLE   | line high, ready for a frame (when CTS allows)
// TX_START  | start bit (0)
// TX_DATA   | data bits, captured order, nbits_q of them
// TX_PARITY | parity bit (parity builds only)
// TX_STOP   | first stop bit (1)
// TX_STOP2  | optional second stop bit (1)
module uart_tx_flex
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int BIT_LEN_W  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_W_MAX-1:0] i_data,
    input  logic [3:0]            i_data_bits,
    input  logic [BIT_LEN_W-1:0]  i_bit_length,
    input  logic                  i_msb_first,
    input  uart_parity_t          i_parity_mode,
    input  logic                  i_stop2,
    input  logic                  i_cts,
    input  logic                  i_hw_flow_control_enable,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    uart_tx_state_t state, state_nxt;

    logic                  tx_q, tx_nxt;
    logic                  done_q;
    logic                  shift;
    logic                  accept;
    logic                  bit_end;
    logic [DATA_W_MAX-1:0] sh;
    logic [DATA_W_MAX-1:0] data_ord;
    logic [DATA_W_MAX-1:0] mask;
    logic [3:0]            nb_cl;
    logic [3:0]            nbits_q;
    logic [3:0]            idx;
    logic [BIT_LEN_W-1:0]  len_q;
    logic                  stop2_q;

    assign o_ready = (state == TX_IDLE) && (i_cts || !i_hw_flow_control_enable);
    assign accept  = i_valid && o_ready;
    assign o_busy  = (state != TX_IDLE);
    assign o_tx    = tx_q;
    assign o_done  = done_q;

    always_comb begin
        nb_cl = i_data_bits;
        if (i_data_bits < 4'(UART_DATA_W_MIN)) begin
            nb_cl = 4'(UART_DATA_W_MIN);
        end else if (i_data_bits > 4'(DATA_W_MAX)) begin
            nb_cl = 4'(DATA_W_MAX);
        end
    end

    // Reorder at capture so the shifter always sends from bit 0.
    always_comb begin
        mask     = '0;
        data_ord = '0;
        for (int i = 0; i < DATA_W_MAX; i++) begin
            mask[i] = (4'(i) < nb_cl);
            if (mask[i]) begin
                data_ord[i] = i_msb_first ? i_data[nb_cl - 4'(i) - 4'd1] : i_data[i];
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_calc;
    logic par_en_c, par_bit_c;
    logic par_en_q, par_bit_q;

    assign par_calc = ^(i_data & mask);

    always_comb begin
        par_en_c  = 1'b1;
        par_bit_c = 1'b0;
        case (i_parity_mode)
            PAR_EVEN:  par_bit_c = par_calc;
            PAR_ODD:   par_bit_c = ~par_calc;
            PAR_MARK:  par_bit_c = 1'b1;
            PAR_SPACE: par_bit_c = 1'b0;
            default:   par_en_c  = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= par_en_c;
            par_bit_q <= par_bit_c;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = ^i_parity_mode;
`endif

    uart_baud_cnt #(
        .BIT_LEN_W (BIT_LEN_W)
    ) u_baud (
        .clk     (i_clk),
        .nrst    (i_nrst),
        .load    (accept),
        .en      (state != TX_IDLE),
        .period  (accept ? i_bit_length : len_q),
        .bit_end (bit_end)
    );

    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_q;
        shift     = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_nxt = 1'b1;
                if (accept) begin
                    state_nxt = TX_START;
                    tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_nxt = TX_DATA;
                    tx_nxt    = sh[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (idx == nbits_q - 4'd1) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_nxt = TX_PARITY;
                            tx_nxt    = par_bit_q;
                        end else begin
                            state_nxt = TX_STOP;
                            tx_nxt    = 1'b1;
                        end
`else
                        state_nxt = TX_STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        tx_nxt = sh[1];
                        shift  = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    state_nxt = TX_STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    state_nxt = stop2_q ? TX_STOP2 : TX_IDLE;
                end
            end
            TX_STOP2: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    state_nxt = TX_IDLE;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state   <= TX_IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            sh      <= '0;
            nbits_q <= '0;
            idx     <= '0;
            len_q   <= '0;
            stop2_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            tx_q   <= tx_nxt;
            done_q <= (state != TX_IDLE) && (state_nxt == TX_IDLE);
            if (accept) begin
                sh      <= data_ord;
                nbits_q <= nb_cl;
                idx     <= '0;
                len_q   <= i_bit_length;
                stop2_q <= i_stop2;
            end else if (shift) begin
                sh  <= sh >> 1;
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_flex.sv
// Directed bench for uart_tx_flex; expected frames are hand-derived bit strings.
// Expectations follow UART_TX_PARITY_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_uart_tx_flex;
    import uart_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_nrst = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [8:0]   i_data = '0;
    logic [3:0]   i_data_bits = 4'd8;
    logic [31:0]  i_bit_length = 32'd1;
    logic         i_msb_first = 1'b0;
    uart_parity_t i_parity_mode = PAR_NONE;
    logic         i_stop2 = 1'b0;
    logic         i_cts = 1'b1;
    logic         i_hw_flow_control_enable = 1'b0;
    logic         o_tx;
    logic         o_busy;
    logic         o_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_flex #(
        .DATA_W_MAX (9),
        .BIT_LEN_W  (32)
    ) dut (
        .i_clk                    (i_clk),
        .i_nrst                   (i_nrst),
        .i_valid                  (i_valid),
        .o_ready                  (o_ready),
        .i_data                   (i_data),
        .i_data_bits              (i_data_bits),
        .i_bit_length             (i_bit_length),
        .i_msb_first              (i_msb_first),
        .i_parity_mode            (i_parity_mode),
        .i_stop2                  (i_stop2),
        .i_cts                    (i_cts),
        .i_hw_flow_control_enable (i_hw_flow_control_enable),
        .o_tx                     (o_tx),
        .o_busy                   (o_busy),
        .o_done                   (o_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cfg(input logic [8:0] data, input logic [3:0] nb, input logic [31:0] len,
                           input logic msb, input uart_parity_t mode, input logic stop2);
        i_data        = data;
        i_data_bits   = nb;
        i_bit_length  = len;
        i_msb_first   = msb;
        i_parity_mode = mode;
        i_stop2       = stop2;
        i_valid       = 1'b1;
    endtask

    // Accepts at the next edge, scrambles inputs, then checks every clock of the frame.
    task automatic run_frame(input string tag, input int nb, input logic [15:0] bits,
                             input int len, input int drop_at);
        @(posedge i_clk);
        #1;
        i_valid       = 1'b0;
        i_data        = ~i_data;
        i_data_bits   = 4'd5;
        i_bit_length  = 32'd7;
        i_msb_first   = ~i_msb_first;
        i_parity_mode = PAR_MARK;
        i_stop2       = ~i_stop2;
        for (int c = 1; c <= nb * len; c++) begin
            @(negedge i_clk);
            check_val({tag, "_tx"}, o_tx, bits[nb - 1 - (c - 1) / len]);
            check_val({tag, "_busy"}, o_busy, 1'b1);
            check_val({tag, "_done"}, o_done, 1'b0);
            if (c == drop_at) i_cts = 1'b0;
        end
        @(negedge i_clk);
        check_val({tag, "_done_end"}, o_done, 1'b1);
        check_val({tag, "_busy_end"}, o_busy, 1'b0);
        check_val({tag, "_tx_end"}, o_tx, 1'b1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int         n1;
        logic [7:0] f1, f2;
        logic [9:0] rf;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_val("rst_tx", o_tx, 1'b1);
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_done", o_done, 1'b0);
        check_val("rst_ready", o_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
        @(negedge i_clk);
        check_val("idle_tx", o_tx, 1'b1);
        @(posedge i_clk);
        #1;

        // 8N1 LSB-first, 4 clocks per bit, 0xA5
        set_cfg(9'h0A5, 4'd8, 32'd4, 1'b0, PAR_NONE, 1'b0);
        run_frame("f8n1", 10, 16'b0101001011, 4, 0);

        // 7E2 MSB-first, 2 clocks per bit, 0x55
        set_cfg(9'h055, 4'd7, 32'd2, 1'b1, PAR_EVEN, 1'b1);
`ifdef UART_TX_PARITY_EN
        run_frame("f7e2", 11, 16'b01010101011, 2, 0);
`else
        run_frame("f7e2", 10, 16'b0101010111, 2, 0);
`endif

        // 8 bits MSB-first with an out-of-range parity code
        set_cfg(9'h00F, 4'd8, 32'd1, 1'b1, uart_parity_t'(3'd7), 1'b0);
        run_frame("fmode7", 10, 16'b0000011111, 1, 0);

        // width 3 clamps to 5, MSB-first, mark parity
        set_cfg(9'h1ED, 4'd3, 32'd1, 1'b1, PAR_MARK, 1'b0);
`ifdef UART_TX_PARITY_EN
        run_frame("fclamp5", 8, 16'b00110111, 1, 0);
`else
        run_frame("fclamp5", 7, 16'b0011011, 1, 0);
`endif

        // width 15 clamps to 9, LSB-first, space parity, 3 clocks per bit
        set_cfg(9'h1A3, 4'd15, 32'd3, 1'b0, PAR_SPACE, 1'b0);
`ifdef UART_TX_PARITY_EN
        run_frame("fclamp9", 12, 16'b011000101101, 3, 0);
`else
        run_frame("fclamp9", 11, 16'b01100010111, 3, 0);
`endif

        // 8 bits odd parity, 0x3C
        set_cfg(9'h03C, 4'd8, 32'd2, 1'b0, PAR_ODD, 1'b0);
`ifdef UART_TX_PARITY_EN
        run_frame("f8o1", 11, 16'b00011110011, 2, 0);
`else
        run_frame("f8o1", 10, 16'b0001111001, 2, 0);
`endif

        // flow control: held off while CTS low, CTS drop mid-frame is ignored
        i_hw_flow_control_enable = 1'b1;
        i_cts = 1'b0;
        set_cfg(9'h05A, 4'd8, 32'd2, 1'b0, PAR_NONE, 1'b0);
        repeat (3) begin
            @(negedge i_clk);
            check_val("fc_ready_low", o_ready, 1'b0);
            check_val("fc_tx_idle", o_tx, 1'b1);
            check_val("fc_busy_idle", o_busy, 1'b0);
        end
        @(posedge i_clk);
        #1;
        i_cts = 1'b1;
        @(negedge i_clk);
        check_val("fc_ready_cts", o_ready, 1'b1);
        run_frame("ffc", 10, 16'b0010110101, 2, 5);
        @(negedge i_clk);
        check_val("fc_ready_after", o_ready, 1'b0);
        @(posedge i_clk);
        #1;
        i_hw_flow_control_enable = 1'b0;
        i_cts = 1'b1;

        // back-to-back 5O1 frames, bit_length 0
`ifdef UART_TX_PARITY_EN
        n1 = 8; f1 = 8'b00110101; f2 = 8'b01100011;
`else
        n1 = 7; f1 = 8'b0011011;  f2 = 8'b0110001;
`endif
        set_cfg(9'h1F6, 4'd5, 32'd0, 1'b0, PAR_ODD, 1'b0);
        @(posedge i_clk);
        #1;
        i_data = 9'h1E3;
        for (int c = 1; c <= 2 * n1 + 2; c++) begin
            @(negedge i_clk);
            if (c <= n1) begin
                check_val("b2b_f1_tx", o_tx, f1[n1 - c]);
                check_val("b2b_f1_done", o_done, 1'b0);
            end else if (c == n1 + 1) begin
                check_val("b2b_mid_done", o_done, 1'b1);
                check_val("b2b_mid_ready", o_ready, 1'b1);
                check_val("b2b_mid_tx", o_tx, 1'b1);
                @(posedge i_clk);
                #1;
                i_valid = 1'b0;
            end else if (c <= 2 * n1 + 1) begin
                check_val("b2b_f2_tx", o_tx, f2[2 * n1 + 1 - c]);
                check_val("b2b_f2_done", o_done, 1'b0);
            end else begin
                check_val("b2b_end_done", o_done, 1'b1);
                check_val("b2b_end_tx", o_tx, 1'b1);
            end
        end
        @(posedge i_clk);
        #1;

        // reset during the data field of a 9N1 frame
        rf = 10'b0110001011;
        set_cfg(9'h1A3, 4'd9, 32'd2, 1'b0, PAR_NONE, 1'b0);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge i_clk);
            check_val("rmid_tx", o_tx, rf[9 - (c - 1) / 2]);
        end
        @(posedge i_clk);
        #1;
        i_nrst = 1'b0;
        @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
        @(negedge i_clk);
        check_val("rmid_tx_after", o_tx, 1'b1);
        check_val("rmid_busy_after", o_busy, 1'b0);
        check_val("rmid_ready_after", o_ready, 1'b1);
        repeat (25) begin
            check_val("rmid_no_done", o_done, 1'b0);
            check_val("rmid_tx_idle", o_tx, 1'b1);
            @(negedge i_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
